// File: rtl/ml_qpi_master.sv
// Byte-oriented quad-SPI (QPI) master: frames transactions with CSB and shifts
// one byte per request as two nibbles, MSB nibble first, for reads or writes.
module ml_qpi_master #(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       xfer_start,
  input  logic       xfer_end,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_read,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       qpi_csb,
  output logic       qpi_clk,
  output logic [3:0] qpi_io_out,
  output logic       qpi_io_oe,
  input  logic [3:0] qpi_io_in,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, SHIFT, FINISH} state_t;

  localparam logic [3:0] HMAX = 4'(CLKDIV - 1);

  state_t     state;
  logic [3:0] hcnt;
  logic [1:0] ph;
  logic       rd_q;
  logic       end_pend;
  logic [3:0] tx_lo;
  logic [7:0] rx_sh;
  logic       handshake;
  logic       half_end;

  assign handshake = (state == ACTIVE) && in_valid && in_ready;
  assign half_end  = (hcnt == HMAX);

  // Control path: ph counts low/high/low/high half-periods of one byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      hcnt       <= 4'd0;
      ph         <= 2'd0;
      rd_q       <= 1'b0;
      end_pend   <= 1'b0;
      qpi_csb    <= 1'b1;
      qpi_clk    <= 1'b0;
      qpi_io_oe  <= 1'b0;
      qpi_io_out <= 4'd0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      busy       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer_start) begin
            state    <= ACTIVE;
            qpi_csb  <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (handshake) begin
            state     <= SHIFT;
            in_ready  <= 1'b0;
            rd_q      <= in_read;
            end_pend  <= xfer_end;
            hcnt      <= 4'd0;
            ph        <= 2'd0;
            qpi_clk   <= 1'b0;
            qpi_io_oe <= !in_read;
            if (!in_read) qpi_io_out <= in_data[7:4];
          end else if (xfer_end) begin
            state    <= FINISH;
            in_ready <= 1'b0;
            qpi_csb  <= 1'b1;
            hcnt     <= 4'd0;
          end
        end
        SHIFT: begin
          if (xfer_end) end_pend <= 1'b1;
          if (half_end) begin
            hcnt <= 4'd0;
            ph   <= ph + 2'd1;
            case (ph)
              2'd0, 2'd2: qpi_clk <= 1'b1;
              2'd1: begin
                qpi_clk <= 1'b0;
                if (!rd_q) qpi_io_out <= tx_lo;
              end
              default: begin
                // Byte complete: a pending end closes the frame, else ask for more.
                qpi_clk   <= 1'b0;
                qpi_io_oe <= 1'b0;
                end_pend  <= 1'b0;
                out_valid <= rd_q;
                if (rd_q) out_data <= rx_sh;
                if (end_pend || xfer_end) begin
                  state   <= FINISH;
                  qpi_csb <= 1'b1;
                end else begin
                  state    <= ACTIVE;
                  in_ready <= 1'b1;
                end
              end
            endcase
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        FINISH: begin
          if (half_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            hcnt  <= 4'd0;
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: low write nibble held for phase 2, read nibbles sampled on qpi_clk rise.
  always_ff @(posedge clk) begin
    if (handshake) tx_lo <= in_data[3:0];
    if ((state == SHIFT) && half_end && !ph[0]) rx_sh <= {rx_sh[3:0], qpi_io_in};
  end

endmodule
